ahb_slave_mem: RTL and testbench
================================

// Module: ahb_slave_mem
// PURPOSE
//  AHB-Lite memory slave; the downstream consumer of the agent's driver stage.
//  Decodes one hsel bit and executes the address/data-phase pipeline.
//  Supports programmable wait states, byte/half/word writes, and the two-cycle ERROR response.
//  Its hrdata/hreadyout/hresp feed the response monitor and scoreboard.
// PARAMETERS
//  SLAVE_ID     0         hsel bit index this slave responds to (0..3)
//  ADDR_BASE    32'h0     byte address of mem[0]
//  MEM_DEPTH    256       number of 32-bit words
//  WAIT_STATES  0         hreadyout-low cycles inserted before every OKAY data phase completes (0..15)
// PORTS
//  hclk       in   1   bus clock, all logic on posedge
//  hreset     in   1   synchronous, active-high reset
//  hsel       in   4   slave selects; only hsel[SLAVE_ID] used
//  haddr      in   32  byte address
//  htrans     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
//  hwrite     in   1   1 write, 0 read
//  hsize      in   3   0 byte, 1 half, 2 word; >2 is an error
//  hburst     in   3   burst type (used only with AHB_SLV_BURST_CHK_EN)
//  hwdata     in   32  write data, valid in write data phase
//  hready     in   1   bus-level ready; address phase sampled only when 1
//  hreadyout  out  1   slave ready
//  hrdata     out  32  read data
//  hresp      out  1   0 OKAY, 1 ERROR
// BEHAVIOUR
//  - Reset: state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter=0, captured phase cleared.
//    Memory contents are not cleared. Reset mid-transfer drops a pending write.
//  - Address-phase accept: hsel[SLAVE_ID] & hready & htrans[1] at a posedge.
//    haddr/hwrite/hsize are latched at that edge; the data phase starts next cycle.
//  - IDLE/BUSY or unselected beats: no data phase; hreadyout=1, hresp=0 (zero-wait OKAY).
//  - Error checks, evaluated on the latched address phase:
//    - hsize>2
//    - misaligned address (half: haddr[0]!=0; word: haddr[1:0]!=0)
//    - (haddr-ADDR_BASE) >= MEM_DEPTH*4, unsigned
//  - State machine:
//    - IDLE -> WAIT (WAIT_STATES>0) | DATA (WAIT_STATES=0) | ERR1 (error) on accept.
//    - WAIT: hreadyout=0, counts WAIT_STATES cycles, then DATA.
//    - DATA: hreadyout=1, hresp=0; the transfer completes at this edge.
//      A new accept at the same edge loops to WAIT/DATA/ERR1; otherwise -> IDLE.
//    - ERR1: hreadyout=0, hresp=1 -> ERR2.
//    - ERR2: hreadyout=1, hresp=1; accept rules as in DATA. An errored write never modifies memory.
//  - Write: mem[word] updated at the DATA completion edge.
//    Byte lanes are little-endian, selected by haddr[1:0] and hsize; unselected lanes are unchanged.
//  - Read: during DATA, hrdata = mem[word] as a full 32-bit word (combinational from the array).
//    hrdata=0 in all other states.
//  - Read-after-write to the same word, back-to-back: the read sees the new data, because the
//    write commits at the edge where the read's data phase begins. No forwarding is required.
//  - Address wrap: word index = (haddr-ADDR_BASE)>>2. No wrap inside memory; out of range errors.
//  - Latency: with WAIT_STATES=N, an OKAY transfer holds its data phase for N+1 cycles.
//    Back-to-back transfers sustain one transfer per N+1 cycles.
// CONFIGURATION
//  AHB_SLV_BURST_CHK_EN defined:
//  - A SEQ beat must address the previous beat's haddr + (1<<hsize).
//    For WRAP4/8/16 the address wraps at a (beats<<hsize) boundary.
//  - A SEQ beat must keep the previous beat's hsize/hwrite/hburst.
//  - A SEQ beat with no preceding accepted NONSEQ/SEQ is a violation.
//  - Any violation gives the ERROR response (ERR1/ERR2) and no memory write.
//  AHB_SLV_BURST_CHK_EN undefined: SEQ is treated exactly like NONSEQ; hburst is ignored.
// TESTING
//  1 Reset held 2 cycles -> hreadyout=1, hresp=0, hrdata=0. Mid-WAIT reset -> IDLE next cycle, write lost.
//  2 WAIT_STATES=0: write word 0xDEADBEEF @0x10, then read @0x10 back-to-back
//    -> read DATA cycle hrdata=0xDEADBEEF, hresp=0.
//  3 Byte write 0xAA @0x13 over 0x11223344 -> read @0x10 returns 0xAA223344.
//    Half write 0x5566 @0x12 -> returns 0x55663344.
//  4 WAIT_STATES=2: read @0x0 -> hreadyout low exactly 2 cycles, then data.
//    A pipelined next address phase is accepted only on the hreadyout=1 edge.
//  5 Read @MEM_DEPTH*4 (and word write @0x2) -> ERR1 (ready=0, resp=1), then ERR2 (ready=1, resp=1).
//    Memory unchanged.
//  6 BURST_CHK_EN: INCR4 word beats at 0x0,0x4,0xC -> third beat ERROR.
//    WRAP4 word beats 0x8,0xC,0x0,0x4 -> all OKAY.

Source files
------------

// File: rtl/ahb_slave_mem.sv
// AHB-Lite word memory slave with programmable wait states and two-cycle ERROR response.
// Define AHB_SLV_BURST_CHK_EN to flag illegal SEQ beats (address/attribute continuity) as errors.
module ahb_slave_mem #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter logic [31:0] ADDR_BASE   = 32'h0,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [3:0]  hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int unsigned IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t         r_state;
  logic [3:0]     r_cnt;
  logic           r_write;
  logic [3:0]     r_be;
  logic [IW-1:0]  r_idx;
  logic           r_hreadyout;
  logic           r_hresp;
  logic [31:0]    r_mem [MEM_DEPTH];

  logic [31:0]    w_off;
  logic           w_accept;
  logic           w_align_err;
  logic           w_range_err;
  logic           w_burst_err;
  logic           w_err;
  logic [3:0]     w_be;

  assign w_off       = haddr - ADDR_BASE;
  assign w_accept    = hsel[SLAVE_ID] & hready & htrans[1];
  assign w_align_err = ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  assign w_range_err = (w_off >= 32'(MEM_DEPTH * 4));

`ifdef AHB_SLV_BURST_CHK_EN
  logic        r_prev_vld;
  logic [31:0] r_prev_addr;
  logic [2:0]  r_prev_size;
  logic [2:0]  r_prev_burst;
  logic        r_prev_write;
  logic [31:0] w_incr;
  logic [31:0] w_bnd;
  logic [31:0] w_exp_addr;
  logic        w_unused;

  // WRAPx bursts (even, non-zero hburst) wrap at (beats << size); beats = 2 << hburst[2:1]
  always_comb begin
    w_incr     = r_prev_addr + (32'd1 << r_prev_size);
    w_bnd      = (32'd2 << r_prev_burst[2:1]) << r_prev_size;
    w_exp_addr = w_incr;
    if (!r_prev_burst[0] && (r_prev_burst != 3'd0))
      w_exp_addr = (r_prev_addr & ~(w_bnd - 32'd1)) | (w_incr & (w_bnd - 32'd1));
    w_burst_err = (htrans == 2'b11) &&
                  (!r_prev_vld || (haddr != w_exp_addr) || (hsize != r_prev_size) ||
                   (hwrite != r_prev_write) || (hburst != r_prev_burst));
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_prev_vld   <= 1'b0;
      r_prev_addr  <= '0;
      r_prev_size  <= '0;
      r_prev_burst <= '0;
      r_prev_write <= 1'b0;
    end else if (w_accept && (r_state != S_WAIT) && (r_state != S_ERR1)) begin
      r_prev_vld   <= 1'b1;
      r_prev_addr  <= haddr;
      r_prev_size  <= hsize;
      r_prev_burst <= hburst;
      r_prev_write <= hwrite;
    end
  end

  assign w_unused = &{1'b0, hsel, w_off[31:IW+2]};
`else
  logic w_unused;
  assign w_burst_err = 1'b0;
  assign w_unused    = &{1'b0, hsel, htrans[0], hburst, w_off[31:IW+2]};
`endif

  assign w_err = (hsize > 3'd2) | w_align_err | w_range_err | w_burst_err;

  always_comb begin
    w_be = 4'b1111;
    case (hsize)
      3'd0:    w_be = 4'b0001 << haddr[1:0];
      3'd1:    w_be = haddr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Only IDLE/DATA/ERR2 drive hreadyout high, so only they may take a new address phase
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_be        <= '0;
      r_idx       <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
        end
        default: begin
          if (w_accept) begin
            r_write <= hwrite;
            r_be    <= w_be;
            r_idx   <= w_off[IW+1:2];
            if (w_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (WAIT_STATES != 0) begin
              r_state     <= S_WAIT;
              r_cnt       <= 4'(WAIT_STATES - 1);
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b0;
            end else begin
              r_state     <= S_DATA;
              r_hreadyout <= 1'b1;
              r_hresp     <= 1'b0;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && (r_state == S_DATA) && r_write) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign hrdata    = ((r_state == S_DATA) && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Two-slave AHB-Lite system (zero-wait and 2-wait slaves) driven by a pipelined master,
// checked against a byte-addressed memory model.
module tb_ahb_slave_mem;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          WS0   = 0;
  localparam int          WS1   = 2;
  localparam int          DEPTH = 256;

  logic        hclk = 1'b0;
  logic        hreset = 1'b1;
  logic [3:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        s0_ready, s1_ready, s0_resp, s1_resp;
  logic [31:0] s0_rdata, s1_rdata;
  logic        dsel;
  logic [31:0] hrdata_b;
  logic        hresp_b;

  typedef struct {
    int          slv;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ferr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] rdq[$];
  int          lowq[$];
  logic [7:0]  mb [2][DEPTH*4];
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 hclk = ~hclk;

  always @(posedge hclk) begin
    if (hreset) dsel <= 1'b0;
    else if (hready) dsel <= hsel[2];
  end

  assign hready   = dsel ? s1_ready : s0_ready;
  assign hrdata_b = dsel ? s1_rdata : s0_rdata;
  assign hresp_b  = dsel ? s1_resp  : s0_resp;

  ahb_slave_mem #(.SLAVE_ID(0), .ADDR_BASE(BASE0), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) u_s0 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(s0_ready), .hrdata(s0_rdata), .hresp(s0_resp));

  ahb_slave_mem #(.SLAVE_ID(2), .ADDR_BASE(BASE1), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) u_s1 (
    .hclk(hclk), .hreset(hreset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(s1_ready), .hrdata(s1_rdata), .hresp(s1_resp));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(int s);
    return (s == 1) ? BASE1 : BASE0;
  endfunction

  function automatic int ws_of(int s);
    return (s == 1) ? WS1 : WS0;
  endfunction

  function automatic beat_t mk(int slv, logic [1:0] trans, logic wr, logic [2:0] size,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [2:0] burst = 3'd0, logic ferr = 1'b0);
    beat_t b;
    b.slv = slv; b.trans = trans; b.wr = wr; b.size = size; b.burst = burst;
    b.addr = addr; b.wdata = wdata; b.ferr = ferr;
    return b;
  endfunction

  function automatic logic model_err(beat_t b);
    logic [31:0] off;
    off = b.addr - base_of(b.slv);
    return b.ferr || (b.size > 3'd2) || ((b.size == 3'd1) && b.addr[0]) ||
           ((b.size == 3'd2) && (b.addr[1:0] != 2'b00)) || (off >= 32'(DEPTH * 4));
  endfunction

  function automatic logic [31:0] model_read(beat_t b);
    int w;
    w = int'(b.addr - base_of(b.slv)) & ~3;
    return {mb[b.slv][w+3], mb[b.slv][w+2], mb[b.slv][w+1], mb[b.slv][w]};
  endfunction

  task automatic model_write(beat_t b);
    int off, a;
    off = int'(b.addr - base_of(b.slv));
    for (int k = 0; k < (1 << b.size); k++) begin
      a = off + k;
      mb[b.slv][a] = b.wdata[8*(a % 4) +: 8];
    end
  endtask

  task automatic drive_addr(beat_t b);
    hsel   = (b.slv == 0) ? 4'b0001 : (b.slv == 1) ? 4'b0100 : 4'b1010;
    haddr  = b.addr;
    htrans = b.trans;
    hwrite = b.wr;
    hsize  = b.size;
    hburst = b.burst;
  endtask

  task automatic drive_idle();
    hsel = 4'b0000; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; hburst = 3'd0;
  endtask

  function automatic beat_t gen();
    beat_t b;
    int r;
    logic [31:0] off;
    r = $urandom_range(0, 9);
    b.slv = (r < 4) ? 0 : (r < 9) ? 1 : 2;
    r = $urandom_range(0, 9);
`ifdef AHB_SLV_BURST_CHK_EN
    b.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b10;
`else
    b.trans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
`endif
    b.wr    = 1'($urandom_range(0, 1));
    b.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    off     = 32'($urandom_range(0, DEPTH - 1)) << 2;
    r = $urandom_range(0, 19);
    if (r == 0)           off = off + 32'($urandom_range(1, 3));
    else if (r == 1)      off = 32'(DEPTH * 4) + (off << 2);
    else if (r == 2)      off = 32'hFFFF_FFFC;
    else if (b.size == 0) off = off + 32'($urandom_range(0, 3));
    else if (b.size == 1) off = off + 32'(2 * $urandom_range(0, 1));
    b.addr  = base_of(b.slv) + off;
    b.wdata = $urandom;
    b.burst = 3'd0;
    b.ferr  = 1'b0;
    return b;
  endfunction

  // Pipelined master: beat i+1 address phase overlaps beat i data phase
  task automatic run();
    int    n, exp_low, low;
    beat_t cur;
    logic  act, err;
    n = q.size();
    rdq.delete();
    lowq.delete();
    if (n == 0) return;
    @(negedge hclk);
    drive_addr(q[0]);
    for (int i = 0; i < n; i++) begin
      cur = q[i];
      @(negedge hclk);
      hwdata = cur.wdata;
      if (i + 1 < n) drive_addr(q[i+1]);
      else drive_idle();
      act     = cur.trans[1] && (cur.slv < 2);
      err     = act && model_err(cur);
      exp_low = !act ? 0 : (err ? 1 : ws_of(cur.slv));
      low     = 0;
      while ((hready === 1'b0) && (low < 40)) begin
        chk("wait_resp", hresp_b, err);
        chk("wait_rdata", hrdata_b, 32'h0);
        low++;
        @(negedge hclk);
      end
      lowq.push_back(low);
      chk("low_cycles", low, exp_low);
      chk("resp", hresp_b, err);
      if (act && !cur.wr) begin
        chk("rdata", hrdata_b, err ? 32'h0 : model_read(cur));
        rdq.push_back(hrdata_b);
      end else if (!act) begin
        chk("idle_rdata", hrdata_b, 32'h0);
      end
      if (cur.slv != 0) chk("quiet0", {s0_ready, s0_resp}, 2'b10);
      if (cur.slv != 1) chk("quiet1", {s1_ready, s1_resp}, 2'b10);
      if (act && cur.wr && !err) model_write(cur);
    end
    q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    hwdata = 32'h0;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_ready0", s0_ready, 1'b1);
    chk("rst_resp0", s0_resp, 1'b0);
    chk("rst_rdata0", s0_rdata, 32'h0);
    chk("rst_ready1", s1_ready, 1'b1);
    chk("rst_resp1", s1_resp, 1'b0);
    chk("rst_rdata1", s1_rdata, 32'h0);
    hreset = 1'b0;

    for (int s = 0; s < 2; s++)
      for (int w = 0; w < DEPTH; w++)
        q.push_back(mk(s, 2'b10, 1'b1, 3'd2, base_of(s) + 32'(w * 4), $urandom));
    run();

    q.push_back(mk(0, 2'b10, 1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF));
    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    run();
    chk("raw_b2b", rdq[0], 32'hDEAD_BEEF);

    q.push_back(mk(0, 2'b10, 1'b1, 3'd2, 32'h10, 32'h1122_3344));
    q.push_back(mk(0, 2'b10, 1'b1, 3'd0, 32'h13, 32'hAA00_0000));
    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    q.push_back(mk(0, 2'b10, 1'b1, 3'd1, 32'h12, 32'h5566_0000));
    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'h10, 32'h0));
    run();
    chk("byte_merge", rdq[0], 32'hAA22_3344);
    chk("half_merge", rdq[1], 32'h5566_3344);

    q.push_back(mk(1, 2'b10, 1'b0, 3'd2, BASE1, 32'h0));
    q.push_back(mk(1, 2'b10, 1'b0, 3'd2, BASE1 + 32'h4, 32'h0));
    run();
    chk("ws2_low_first", lowq[0], 32'd2);
    chk("ws2_low_pipelined", lowq[1], 32'd2);

    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0));
    q.push_back(mk(0, 2'b10, 1'b1, 3'd2, 32'h2, 32'hFFFF_FFFF));
    q.push_back(mk(0, 2'b10, 1'b1, 3'd3, 32'h0, 32'hFFFF_FFFF));
    q.push_back(mk(1, 2'b10, 1'b0, 3'd2, BASE1 - 32'h4, 32'h0));
    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0));
    run();
    chk("err_range_low", lowq[0], 32'd1);
    chk("err_unchanged", rdq[2], model_read(mk(0, 2'b10, 1'b0, 3'd2, 32'h0, 32'h0)));

`ifdef AHB_SLV_BURST_CHK_EN
    q.push_back(mk(0, 2'b10, 1'b1, 3'd2, 32'h0, 32'h0101_0101, 3'd3));
    q.push_back(mk(0, 2'b11, 1'b1, 3'd2, 32'h4, 32'h0202_0202, 3'd3));
    q.push_back(mk(0, 2'b11, 1'b1, 3'd2, 32'hC, 32'h0303_0303, 3'd3, 1'b1));
    q.push_back(mk(0, 2'b10, 1'b0, 3'd2, 32'h8, 32'h0, 3'd2));
    q.push_back(mk(0, 2'b11, 1'b0, 3'd2, 32'hC, 32'h0, 3'd2));
    q.push_back(mk(0, 2'b11, 1'b0, 3'd2, 32'h0, 32'h0, 3'd2));
    q.push_back(mk(0, 2'b11, 1'b0, 3'd2, 32'h4, 32'h0, 3'd2));
    run();
    chk("incr4_third_err", lowq[2], 32'd1);
    chk("wrap4_wrap_ok", rdq[2], 32'h0101_0101);
`endif

    for (int i = 0; i < 400; i++) q.push_back(gen());
    run();

    q.push_back(mk(1, 2'b10, 1'b1, 3'd2, BASE1, 32'h0BAD_F00D));
    run();
    @(negedge hclk);
    drive_addr(mk(1, 2'b10, 1'b1, 3'd2, BASE1, 32'hFFFF_FFFF));
    @(negedge hclk);
    hwdata = 32'hFFFF_FFFF;
    drive_idle();
    chk("midwait_ready", s1_ready, 1'b0);
    hreset = 1'b1;
    @(negedge hclk);
    hreset = 1'b0;
    chk("post_rst_ready", s1_ready, 1'b1);
    chk("post_rst_resp", s1_resp, 1'b0);
    q.push_back(mk(1, 2'b10, 1'b0, 3'd2, BASE1, 32'h0));
    run();
    chk("rst_drops_write", rdq[0], 32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
